// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and stall encodings for the pipeline stall controller.
// Stall vector bit order is {wb, mem, ex, id, if, pc}; a 1 stops that stage.
package pipe_stall_ctrl_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    localparam logic [5:0] STALL_NONE    = 6'b000000;
    localparam logic [5:0] STALL_FROM_ID = 6'b000111;
    // ex_mem is stopped but mem_wb is not, so a bubble enters MEM.
    localparam logic [5:0] STALL_FROM_EX = 6'b001111;

endpackage

// File: rtl/pipe_stall_ctrl_mc_hold_cnt.sv
// Multi-cycle EX hold sequencer: IDLE/BUSY FSM with a down-counter.
// An N-cycle op holds EX for N-1 cycles and signals done on cycle N.
module mc_hold_cnt
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                abort,
    input  logic                start,
    input  logic [MC_CNT_W-1:0] cycles,
    output logic                hold,
    output logic                done,
    output logic                busy
);

    mc_state_t           state_reg, state_next;
    logic [MC_CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // cnt is only ever loaded with N-1 >= 1 and leaves BUSY at 1, so it cannot wrap.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (abort) begin
            state_next = MC_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                MC_IDLE: begin
                    if (start && (cycles >= MC_CNT_W'(2))) begin
                        state_next = MC_BUSY;
                        cnt_next   = cycles - MC_CNT_W'(1);
                    end
                end
                MC_BUSY: begin
                    if (cnt_reg > MC_CNT_W'(1)) begin
                        cnt_next = cnt_reg - MC_CNT_W'(1);
                    end else begin
                        state_next = MC_IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = MC_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        hold = 1'b0;
        done = 1'b0;
        busy = 1'b0;
        case (state_reg)
            MC_IDLE: begin
                if (start) begin
                    if (cycles <= MC_CNT_W'(1)) done = 1'b1;
                    else                        hold = 1'b1;
                end
            end
            MC_BUSY: begin
                busy = 1'b1;
                if (cnt_reg > MC_CNT_W'(1)) hold = 1'b1;
                else                        done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: merges ID/EX stall requests with MEM flushes into the stall vector.
// Optional counters perf_stall_cycles/perf_flush_cnt are built when PIPE_STALL_PERF_EN is defined.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6,
    parameter int PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_CNT_W-1:0] ex_mc_cycles,
    input  logic                flush_req,
    input  logic [PC_W-1:0]     flush_pc,
    output logic [5:0]          stall,
    output logic                ex_mc_done,
    output logic                mc_busy,
    output logic                flush,
    output logic [PC_W-1:0]     new_pc
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_flush_cnt
`endif
);

    logic            flush_reg;
    logic [PC_W-1:0] new_pc_reg;
    logic            live;
    logic            mc_start;
    logic            mc_hold;
    logic            mc_done;
    logic            mc_busy_int;

    // The flushing cycle squashes everything: no stall, no done, no new op.
    assign live     = ~rst & ~flush_reg;
    assign mc_start = ex_mc_start & live;

    mc_hold_cnt #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .abort  (flush_req),
        .start  (mc_start),
        .cycles (ex_mc_cycles),
        .hold   (mc_hold),
        .done   (mc_done),
        .busy   (mc_busy_int)
    );

    always_comb begin
        stall = STALL_NONE;
        if (live) begin
            if (mc_hold)          stall = STALL_FROM_EX;
            else if (stallreq_id) stall = STALL_FROM_ID;
        end
    end

    assign ex_mc_done = mc_done & live;
    assign mc_busy    = mc_busy_int & ~rst;
    assign flush      = flush_reg;
    assign new_pc     = new_pc_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_reg  <= 1'b0;
            new_pc_reg <= '0;
        end else begin
            flush_reg <= flush_req;
            if (flush_req) new_pc_reg <= flush_pc;
        end
    end

`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    // Flush counter bumps on the edge where flush goes 0 -> 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if ((stall != STALL_NONE) && (perf_stall_reg != 32'hFFFF_FFFF))
                perf_stall_reg <= perf_stall_reg + 32'd1;
            if (flush_req && !flush_reg && (perf_flush_reg != 32'hFFFF_FFFF))
                perf_flush_reg <= perf_flush_reg + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_reg;
    assign perf_flush_cnt    = perf_flush_reg;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-numbered behavioural model of the sequencer.
module tb_pipe_stall_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_ID   = 6'b000111;
    localparam logic [5:0] S_EX   = 6'b001111;

    logic        clk = 1'b0;
    logic        rst, stallreq_id, ex_mc_start, flush_req;
    logic [5:0]  ex_mc_cycles;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        ex_mc_done, mc_busy, flush;
    logic [31:0] new_pc;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_CNT_W(6), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .ex_mc_done   (ex_mc_done),
        .mc_busy      (mc_busy),
        .flush        (flush),
        .new_pc       (new_pc)
`ifdef PIPE_STALL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: an accepted op of N cycles started at cycle c finishes at cycle c+N-1.
    int          cyc       = 0;
    bit          m_op      = 0;
    int          m_done_at = 0;
    bit          m_flush   = 0;
    logic [31:0] m_npc     = '0;
    int          m_stall_cnt = 0;
    int          m_flush_cnt = 0;
    logic [5:0]  exp_stall;
    bit          exp_done, exp_busy;

    task automatic model_eval();
        bit hold;
        hold = 0; exp_done = 0; exp_busy = 0;
        if (!rst && !m_flush) begin
            if (m_op) begin
                exp_busy = 1;
                if (cyc < m_done_at) hold = 1; else exp_done = 1;
            end else if (ex_mc_start) begin
                if (ex_mc_cycles <= 6'd1) exp_done = 1; else hold = 1;
            end
        end
        if (rst || m_flush) exp_stall = S_NONE;
        else if (hold)      exp_stall = S_EX;
        else if (stallreq_id) exp_stall = S_ID;
        else                exp_stall = S_NONE;
    endtask

    task automatic model_update();
        if (rst) begin
            m_op = 0; m_flush = 0; m_npc = '0; m_stall_cnt = 0; m_flush_cnt = 0;
        end else begin
            if (exp_stall != S_NONE) m_stall_cnt++;
            if (flush_req && !m_flush) m_flush_cnt++;
            if (flush_req) m_op = 0;
            else if (!m_flush) begin
                if (m_op) begin
                    if (cyc == m_done_at) m_op = 0;
                end else if (ex_mc_start && ex_mc_cycles >= 6'd2) begin
                    m_op = 1;
                    m_done_at = cyc + int'(ex_mc_cycles) - 1;
                end
            end
            m_flush = flush_req;
            if (flush_req) m_npc = flush_pc;
        end
        cyc++;
    endtask

    // Apply one cycle's inputs, then settle at the falling edge for sampling.
    task automatic drive(input bit r, input bit id, input bit st, input int n,
                         input bit fr, input logic [31:0] fpc);
        rst = r; stallreq_id = id; ex_mc_start = st; ex_mc_cycles = n[5:0];
        flush_req = fr; flush_pc = fpc;
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 5, 1, 32'hDEAD_BEEF);
        tests_run++; if (stall !== S_NONE) begin tests_failed++; $display("FAIL reset_stall got %b exp %b", stall, S_NONE); end
        tests_run++; if (ex_mc_done !== 1'b0 || mc_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_done_busy got %b/%b exp 0/0", ex_mc_done, mc_busy); end
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (flush !== 1'b0 || new_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_flush got %b/%h exp 0/0", flush, new_pc); end
        tests_run++; if (mc_busy !== 1'b0 || stall !== S_NONE) begin tests_failed++; $display("FAIL reset_idle got busy %b stall %b exp 0/000000", mc_busy, stall); end
        tick();
        $display("[TB] test_reset done");
    endtask

    task automatic test_id_stall();
        drive(0, 1, 0, 0, 0, 32'h0);
        tests_run++; if (stall !== S_ID || flush !== 1'b0) begin tests_failed++; $display("FAIL id_stall got %b flush %b exp %b flush 0", stall, flush, S_ID); end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (stall !== S_NONE) begin tests_failed++; $display("FAIL id_release got %b exp %b", stall, S_NONE); end
        tick();
        $display("[TB] test_id_stall done");
    endtask

    task automatic test_multicycle();
        logic [5:0] es [5] = '{S_EX, S_EX, S_EX, S_NONE, S_NONE};
        bit         eb [5] = '{0, 1, 1, 1, 0};
        bit         ed [5] = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, i == 0, 4, 0, 32'h0);
            tests_run++;
            if (stall !== es[i] || mc_busy !== eb[i] || ex_mc_done !== ed[i]) begin
                tests_failed++;
                $display("FAIL mc_n4_c%0d got stall %b busy %b done %b exp %b %b %b",
                         i + 1, stall, mc_busy, ex_mc_done, es[i], eb[i], ed[i]);
            end
            tick();
        end
        drive(0, 0, 1, 1, 0, 32'h0);
        tests_run++; if (stall !== S_NONE || ex_mc_done !== 1'b1 || mc_busy !== 1'b0) begin tests_failed++; $display("FAIL mc_n1 got stall %b done %b busy %b exp 000000 1 0", stall, ex_mc_done, mc_busy); end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin tests_failed++; $display("FAIL mc_n1_after got busy %b done %b exp 0 0", mc_busy, ex_mc_done); end
        tick();
        $display("[TB] test_multicycle done");
    endtask

    task automatic test_flush_busy();
        int dones = 0;
        drive(0, 0, 1, 6, 0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h0000_0040);
        tick();
        // start and id requests in the flush cycle must be ignored
        drive(0, 1, 1, 4, 0, 32'h0);
        tests_run++; if (flush !== 1'b1 || new_pc !== 32'h40) begin tests_failed++; $display("FAIL flush_reg got %b/%h exp 1/00000040", flush, new_pc); end
        tests_run++; if (stall !== S_NONE || mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin tests_failed++; $display("FAIL flush_squash got stall %b busy %b done %b exp 000000 0 0", stall, mc_busy, ex_mc_done); end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (flush !== 1'b0 || mc_busy !== 1'b0) begin tests_failed++; $display("FAIL flush_release got flush %b busy %b exp 0 0", flush, mc_busy); end
        for (int i = 0; i < 8; i++) begin
            if (ex_mc_done === 1'b1) dones++;
            tick();
            drive(0, 0, 0, 0, 0, 32'h0);
        end
        tests_run++; if (dones != 0) begin tests_failed++; $display("FAIL flush_no_done got %0d done pulses exp 0", dones); end
        tick();
        $display("[TB] test_flush_busy done");
    endtask

    task automatic test_id_during_busy();
        logic [5:0] es [3] = '{S_EX, S_EX, S_ID};
        bit         ed [3] = '{0, 0, 1};
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i == 0, 3, 0, 32'h0);
            tests_run++;
            if (stall !== es[i] || ex_mc_done !== ed[i]) begin
                tests_failed++;
                $display("FAIL id_busy_c%0d got stall %b done %b exp %b %b", i + 1, stall, ex_mc_done, es[i], ed[i]);
            end
            tick();
        end
        $display("[TB] test_id_during_busy done");
    endtask

    task automatic test_rst_mid_busy();
        drive(0, 0, 1, 10, 0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 32'h0);
        tests_run++; if (stall !== S_NONE || mc_busy !== 1'b0 || ex_mc_done !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_comb got stall %b busy %b done %b exp 000000 0 0", stall, mc_busy, ex_mc_done); end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (stall !== S_NONE || mc_busy !== 1'b0 || ex_mc_done !== 1'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_busy_after got stall %b busy %b done %b flush %b pc %h exp all 0", stall, mc_busy, ex_mc_done, flush, new_pc); end
        tick();
        drive(0, 0, 1, 2, 0, 32'h0);
        tests_run++; if (stall !== S_EX || ex_mc_done !== 1'b0) begin tests_failed++; $display("FAIL rst_n2_c1 got stall %b done %b exp %b 0", stall, ex_mc_done, S_EX); end
        tick();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (stall !== S_NONE || ex_mc_done !== 1'b1 || mc_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_n2_c2 got stall %b done %b busy %b exp 000000 1 1", stall, ex_mc_done, mc_busy); end
        tick();
        $display("[TB] test_rst_mid_busy done");
    endtask

    task automatic test_random();
        int errs_before = tests_failed;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 6) == 0, int'($urandom_range(0, 12)),
                  $urandom_range(0, 11) == 0, $urandom);
            tests_run++;
            if (stall !== exp_stall || ex_mc_done !== exp_done || mc_busy !== exp_busy) begin
                tests_failed++;
                $display("FAIL rand_comb cyc %0d got stall %b done %b busy %b exp %b %b %b",
                         cyc, stall, ex_mc_done, mc_busy, exp_stall, exp_done, exp_busy);
            end
            tests_run++;
            if (flush !== m_flush || (m_flush && new_pc !== m_npc)) begin
                tests_failed++;
                $display("FAIL rand_flush cyc %0d got %b/%h exp %b/%h", cyc, flush, new_pc, m_flush, m_npc);
            end
            tick();
        end
        $display("[TB] test_random done, %0d new failures", tests_failed - errs_before);
    endtask

`ifdef PIPE_STALL_PERF_EN
    task automatic test_perf();
        drive(0, 0, 0, 0, 0, 32'h0);
        tests_run++; if (perf_stall_cycles !== 32'(m_stall_cnt)) begin tests_failed++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cycles, m_stall_cnt); end
        tests_run++; if (perf_flush_cnt !== 32'(m_flush_cnt)) begin tests_failed++; $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, m_flush_cnt); end
        tick();
        $display("[TB] test_perf done");
    endtask
`endif

    initial begin
        test_reset();
        test_id_stall();
        test_multicycle();
        test_flush_busy();
        test_id_during_busy();
        test_rst_mid_busy();
        test_random();
`ifdef PIPE_STALL_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
